rx_watchdog_nch: RTL

RX_WATCHDOG_NCH -- requirements
Module: rx_watchdog_nch

---
 rtl/rx_watchdog_nch.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rx_watchdog_nch.sv
// Receiver watchdog: per-channel DC bias, SIGNAL length and equalizer monitors.
// Define RX_WATCHDOG_FAULT_CNT_EN to implement the saturating fault_count.
module rx_watchdog_nch #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int NUM_CH        = 2,
  parameter int DC_WIN_LOG2   = 6,
  parameter int DC_ANY_CH     = 0,
  parameter int RST_HOLD      = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] sample_in,
  input  logic                            sample_in_strobe,
  input  logic                            power_trigger,
  input  logic [15:0]                     sig_len,
  input  logic                            sig_valid,
  input  logic [3:0]                      min_len_th,
  input  logic [15:0]                     max_len_th,
  input  logic [7:0]                      dc_th,
  input  logic                            eq_monitor_en,
  input  logic [5:0]                      eq_small_th,
  input  logic [31:0]                     equalizer,
  input  logic                            equalizer_valid,
  output logic                            receiver_rst,
  output logic [3:0]                      rst_cause,
  output logic [15:0]                     fault_count
);

  localparam int AW = DC_WIN_LOG2 + 2;
  localparam int W2 = 2 * IQ_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MONITOR,
    HOLD,
    COOLDOWN
  } state_t;

  state_t state;
  logic [3:0] tmr;

  logic in_mon;
  assign in_mon = (state == MONITOR);

  // DC monitor: shared window, sign-counting accumulators
  logic [DC_WIN_LOG2-1:0] win_cnt;
  logic dc_run, dc_step, win_wrap;
  logic [NUM_CH-1:0] ch_fault;
  logic dc_fault;

  assign dc_run   = in_mon && enable && power_trigger;
  assign dc_step  = dc_run && sample_in_strobe;
  assign win_wrap = dc_step && (win_cnt == '1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      win_cnt <= '0;
    else if (!dc_run)
      win_cnt <= '0;
    else if (dc_step)
      win_cnt <= win_cnt + 1'b1;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam int B = ch * W2;
    logic i_neg, q_neg;
    logic signed [AW-1:0] acc_i, acc_q;
    logic signed [AW-1:0] nxt_i, nxt_q;
    logic [AW-1:0] mag_i, mag_q;

    assign i_neg = sample_in[B+W2-1];
    assign q_neg = sample_in[B+IQ_DATA_WIDTH-1];

    assign nxt_i = i_neg ? acc_i - AW'(1) : acc_i + AW'(1);
    assign nxt_q = q_neg ? acc_q - AW'(1) : acc_q + AW'(1);
    assign mag_i = nxt_i[AW-1] ? AW'(-nxt_i) : AW'(nxt_i);
    assign mag_q = nxt_q[AW-1] ? AW'(-nxt_q) : AW'(nxt_q);

    assign ch_fault[ch] = (dc_th != 8'd0) &&
      ((32'(mag_i) >= 32'(dc_th)) ||
       (32'(mag_q) >= 32'(dc_th)));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        acc_i <= '0;
        acc_q <= '0;
      end else if (!dc_run || win_wrap) begin
        acc_i <= '0;
        acc_q <= '0;
      end else if (dc_step) begin
        acc_i <= nxt_i;
        acc_q <= nxt_q;
      end
    end
  end

  assign dc_fault = win_wrap &&
    ((DC_ANY_CH != 0) ? (|ch_fault) : (&ch_fault));

  // Length monitor
  logic len_run, short_fault, long_fault;
  assign len_run     = in_mon && enable && sig_valid;
  assign short_fault = len_run && (sig_len < {12'd0, min_len_th});
  assign long_fault  = len_run && (sig_len > max_len_th);

  // Equalizer monitor: count near-zero constellation points
  localparam logic signed [15:0] EQ_LO = -16'sd4;
  localparam logic signed [15:0] EQ_HI = 16'sd3;

  logic signed [15:0] eq_i, eq_q;
  logic [5:0] eq_cnt;
  logic eq_small, eq_hit, eq_fault;

  assign eq_i     = equalizer[31:16];
  assign eq_q     = equalizer[15:0];
  assign eq_small = (eq_i >= EQ_LO) && (eq_i <= EQ_HI) &&
                    (eq_q >= EQ_LO) && (eq_q <= EQ_HI);
  assign eq_hit   = in_mon && eq_monitor_en && (eq_small_th != 6'd0) &&
                    equalizer_valid && eq_small;
  assign eq_fault = eq_hit &&
    (({1'b0, eq_cnt} + 7'd1) >= {1'b0, eq_small_th});

  logic [3:0] faults;
  logic go_hold;
  assign faults  = {eq_fault, long_fault, short_fault, dc_fault};
  assign go_hold = in_mon && (faults != 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      eq_cnt <= '0;
    else if (!eq_monitor_en || go_hold)
      eq_cnt <= '0;
    else if (eq_hit && (eq_cnt != 6'h3f))
      eq_cnt <= eq_cnt + 6'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tmr          <= '0;
      receiver_rst <= 1'b0;
      rst_cause    <= '0;
    end else begin
      unique case (state)
        IDLE: state <= MONITOR;
        MONITOR: begin
          if (go_hold) begin
            state        <= HOLD;
            receiver_rst <= 1'b1;
            rst_cause    <= faults;
            tmr          <= 4'(RST_HOLD - 1);
          end
        end
        HOLD: begin
          if (tmr == 4'd0) begin
            state        <= COOLDOWN;
            receiver_rst <= 1'b0;
            tmr          <= 4'd1;
          end else begin
            tmr <= tmr - 4'd1;
          end
        end
        COOLDOWN: begin
          if (tmr == 4'd0)
            state <= MONITOR;
          else
            tmr <= tmr - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_WATCHDOG_FAULT_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      fault_count <= '0;
    else if (go_hold && (fault_count != 16'hffff))
      fault_count <= fault_count + 16'd1;
  end
`else
  assign fault_count = 16'd0;
`endif

endmodule
